// File: rtl/line_win_gather_if.sv
// Stream and control bundle between the line buffer bank, the window gather
// stage and the downstream kernel. Signal suffixes are from the gather
// stage's point of view. The gather stage uses the slave modport and its
// environment uses the master modport.
interface line_win_gather_if #(
   parameter int WIN_SIZE = 3,
   parameter int PX_WIDTH = 30
);
   logic [WIN_SIZE-1:0]          empty_i;
   logic [WIN_SIZE-1:0]          unread_i;
   logic [WIN_SIZE-1:0]          pop_line_o;
   logic [WIN_SIZE*PX_WIDTH-1:0] line_tdata_i;
   logic [WIN_SIZE-1:0]          line_tvalid_i;
   logic [WIN_SIZE-1:0]          line_tlast_i;
   logic [WIN_SIZE-1:0]          line_tuser_i;
   logic [WIN_SIZE-1:0]          line_tready_o;
   logic [WIN_SIZE*PX_WIDTH-1:0] win_tdata_o;
   logic                         win_tvalid_o;
   logic                         win_tlast_o;
   logic                         win_tuser_o;
   logic                         win_tready_i;

   modport slave (
      input  empty_i, unread_i, line_tdata_i, line_tvalid_i, line_tlast_i,
             line_tuser_i, win_tready_i,
      output pop_line_o, line_tready_o, win_tdata_o, win_tvalid_o,
             win_tlast_o, win_tuser_o
   );

   modport master (
      output empty_i, unread_i, line_tdata_i, line_tvalid_i, line_tlast_i,
             line_tuser_i, win_tready_i,
      input  pop_line_o, line_tready_o, win_tdata_o, win_tvalid_o,
             win_tlast_o, win_tuser_o
   );
endinterface

// File: rtl/line_win_gather.sv
// line_win_gather: pops WIN_SIZE line buffers together once each holds a
// complete unread line, then merges their pixel streams beat by beat into
// one window-column stream through a single output register.
// Optional checker: define LINE_WIN_GATHER_CHK_EN to build the sticky
// misalignment flag err_o (split tlast, or line length change). Without it
// err_o is tied low and only line 0's tlast is looked at.
module line_win_gather #(
   parameter int WIN_SIZE      = 3,
   parameter int PX_WIDTH      = 30,
   parameter int MAX_LINE_SIZE = 1920,
   localparam int LEN_WIDTH    = $clog2(MAX_LINE_SIZE + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   line_win_gather_if.slave      bus,
   output logic [LEN_WIDTH-1:0]  line_len_o,
   output logic                  busy_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      POP    = 2'd1,
      STREAM = 2'd2
   } state_e;

   state_e                       state_q;
   logic [WIN_SIZE-1:0]          pop_q;
   logic [WIN_SIZE*PX_WIDTH-1:0] data_q;
   logic                         tvalid_q;
   logic                         tlast_q;
   logic                         tuser_q;
   logic [LEN_WIDTH-1:0]         cnt_q;
   logic [LEN_WIDTH-1:0]         len_q;

   logic                         acc;
   logic                         out_hs;
   logic                         start;
   logic [LEN_WIDTH-1:0]         cnt_d;

   // A beat moves only when every buffer offers one and the output register
   // is free or emptying, so all buffers advance in lockstep.
   assign acc    = (state_q == STREAM) && (&bus.line_tvalid_i) &&
                   (!tvalid_q || bus.win_tready_i);
   assign out_hs = tvalid_q && bus.win_tready_i;
   // A new line is only started once the previous last beat has left.
   assign start  = (&bus.unread_i) && !(|bus.empty_i) && !tvalid_q;
   // Beat count after this beat, saturating at the maximum line size.
   assign cnt_d  = (cnt_q >= LEN_WIDTH'(MAX_LINE_SIZE)) ?
                   LEN_WIDTH'(MAX_LINE_SIZE) : cnt_q + 1'b1;

   // Control FSM together with the registered output stage and length tracking.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         pop_q    <= '0;
         data_q   <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         cnt_q    <= '0;
         len_q    <= '0;
      end else begin
         pop_q <= '0;

         if (acc) begin
            data_q   <= bus.line_tdata_i;
            tlast_q  <= bus.line_tlast_i[0];
            tuser_q  <= |bus.line_tuser_i;
            tvalid_q <= 1'b1;
         end else if (out_hs) begin
            tvalid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= POP;
                  pop_q   <= '1;
               end
            end
            POP: begin
               state_q <= STREAM;
               cnt_q   <= '0;
            end
            STREAM: begin
               if (acc) begin
                  cnt_q <= cnt_d;
                  if (bus.line_tlast_i[0]) begin
                     len_q   <= cnt_d;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pop_line_o    = pop_q;
   assign bus.line_tready_o = {WIN_SIZE{acc}};
   assign bus.win_tdata_o   = data_q;
   assign bus.win_tvalid_o  = tvalid_q;
   assign bus.win_tlast_o   = tlast_q;
   assign bus.win_tuser_o   = tuser_q;
   assign line_len_o        = len_q;
   assign busy_o            = (state_q != IDLE);

`ifdef LINE_WIN_GATHER_CHK_EN
   logic err_q;
   logic tlast_split;
   logic len_change;

   // Buffers disagree on end-of-line, or this line's length differs from the
   // previous completed one (len_q is zero only before the first line).
   assign tlast_split = !((&bus.line_tlast_i) || !(|bus.line_tlast_i));
   assign len_change  = (len_q != '0) && (cnt_d != len_q);

   // Sticky misalignment flag, cleared only by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (acc && (tlast_split || (bus.line_tlast_i[0] && len_change))) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   // Only line 0 carries end-of-line information in this build.
   logic unused_tlast;
   assign unused_tlast = ^bus.line_tlast_i[WIN_SIZE-1:0];
   assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_line_win_gather.sv
// Bench for line_win_gather: models three line buffers, pushes expected
// window beats to a scoreboard when a line is loaded, and pops/compares them
// as the DUT emits beats.
module tb_line_win_gather;
   localparam int WIN = 3;
   localparam int PXW = 30;
   localparam int DW  = WIN * PXW;
   localparam int LW  = $clog2(1920 + 1);

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [LW-1:0] line_len_o;
   logic          busy_o;
   logic          err_o;

   line_win_gather_if #(.WIN_SIZE(WIN), .PX_WIDTH(PXW)) bus ();

   line_win_gather #(.WIN_SIZE(WIN), .PX_WIDTH(PXW), .MAX_LINE_SIZE(1920)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bus        (bus),
      .line_len_o (line_len_o),
      .busy_o     (busy_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // buffer model
   int idx[WIN];
   int len_l[WIN];
   int last_at[WIN];
   bit loaded[WIN];
   bit popped[WIN];
   bit hold[WIN];
   bit stall[WIN];
   int base;
   bit sof;

   beat_t sb[$];
   int    beats_out = 0;
   bit    exp_err = 1'b0;
   int    prev_len = 0;

   // sampled DUT state (taken on the falling edge)
   logic [WIN-1:0] s_pop, s_rdy, s_tvin;
   logic           s_tv, s_wt, s_last, s_user, s_busy;
   logic [DW-1:0]  s_data;
   bit             hold_pend = 1'b0;
   logic [DW+1:0]  held;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < WIN; k++) begin
         bus.unread_i[k]      = loaded[k] && !popped[k] && !hold[k];
         bus.empty_i[k]       = !loaded[k];
         bus.line_tvalid_i[k] = popped[k] && (idx[k] < len_l[k]) && !stall[k];
         bus.line_tdata_i[k*PXW +: PXW] = PXW'(base + k * 16 + idx[k]);
         bus.line_tlast_i[k]  = (idx[k] == last_at[k]);
         bus.line_tuser_i[k]  = sof && (k == 2) && (idx[k] == 0);
      end
   endtask

   // One clock cycle: drive, sample on the falling edge, then update the
   // buffer model and scoreboard after the rising edge.
   task automatic step();
      beat_t e;
      drive();
      @(negedge clk_i);
      s_pop  = bus.pop_line_o;
      s_rdy  = bus.line_tready_o;
      s_tvin = bus.line_tvalid_i;
      s_tv   = bus.win_tvalid_o;
      s_wt   = bus.win_tready_i;
      s_data = bus.win_tdata_o;
      s_last = bus.win_tlast_o;
      s_user = bus.win_tuser_o;
      s_busy = busy_o;
      if (stall[0] || stall[1] || stall[2])
         chk("stall_tready", s_rdy, '0);
      if (hold_pend)
         chk("hold_stable", {s_tv, s_last, s_data}, held);
      hold_pend = s_tv && !s_wt;
      held      = {s_tv, s_last, s_data};
      @(posedge clk_i);
      #1;
      if (s_pop == '1)
         for (int k = 0; k < WIN; k++) popped[k] = 1'b1;
      for (int k = 0; k < WIN; k++) begin
         if (s_rdy[k] && s_tvin[k]) begin
            idx[k]++;
            if (idx[k] >= len_l[k]) begin
               loaded[k] = 1'b0;
               popped[k] = 1'b0;
            end
         end
      end
      if (s_tv && s_wt) begin
         beats_out++;
         $display("beat %0d data=%h last=%0b user=%0b", beats_out, s_data, s_last, s_user);
         if (sb.size() == 0) begin
            chk("extra_beat", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("beat_data", s_data, e.data);
            chk("beat_last", s_last, e.last);
            chk("beat_user", s_user, e.user);
         end
      end
   endtask

   task automatic load_line(input int len, input int b, input bit sofx, input int early_at);
      beat_t e;
      base = b;
      sof  = sofx;
      for (int k = 0; k < WIN; k++) begin
         idx[k]     = 0;
         len_l[k]   = len;
         last_at[k] = (k == 1 && early_at >= 0) ? early_at : len - 1;
         loaded[k]  = 1'b1;
         popped[k]  = 1'b0;
         stall[k]   = 1'b0;
         hold[k]    = 1'b0;
      end
      for (int i = 0; i < len; i++) begin
         for (int k = 0; k < WIN; k++) e.data[k*PXW +: PXW] = PXW'(b + k * 16 + i);
         e.last = (i == len - 1);
         e.user = sofx && (i == 0);
         sb.push_back(e);
      end
`ifdef LINE_WIN_GATHER_CHK_EN
      if (early_at >= 0) exp_err = 1'b1;
      if (prev_len != 0 && prev_len != len) exp_err = 1'b1;
`endif
      prev_len = len;
   endtask

   task automatic run_line(input int len, input int b, input bit bp, input int stall_at,
                           input int stall_len, input bit sofx, input int early_at, input bit gate);
      int pops_seen = 0;
      int first_pop = -1;
      int cyc = 0;
      int stall_cnt = 0;
      load_line(len, b, sofx, early_at);
      if (gate) begin
         hold[2] = 1'b1;
         repeat (20) begin
            step();
            chk("gate_pop", s_pop, '0);
            chk("gate_tready", s_rdy, '0);
            chk("gate_busy", s_busy, 0);
         end
         hold[2] = 1'b0;
      end
      while (cyc < 400) begin
         bus.win_tready_i = bp ? ~bus.win_tready_i : 1'b1;
         stall[1] = 1'b0;
         if (stall_at >= 0 && popped[1] && idx[1] == stall_at && stall_cnt < stall_len) begin
            stall[1] = 1'b1;
            stall_cnt++;
         end
         step();
         if (s_pop == '1) begin
            pops_seen++;
            if (first_pop < 0) first_pop = cyc;
         end
         cyc++;
         if (sb.size() == 0 && !loaded[0] && !loaded[1] && !loaded[2]) break;
      end
      stall[1] = 1'b0;
      if (cyc >= 400) chk("drain_timeout", 1, 0);
      chk("pop_count", pops_seen, 1);
      chk("pop_latency", first_pop, 1);
      chk("line_len", line_len_o, len);
      chk("busy_after", busy_o, 0);
      chk("err_flag", err_o, exp_err);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_pop"}, bus.pop_line_o, '0);
      chk({tag, "_tready"}, bus.line_tready_o, '0);
      chk({tag, "_tvalid"}, bus.win_tvalid_o, 0);
      chk({tag, "_tdata"}, bus.win_tdata_o, '0);
      chk({tag, "_tlast"}, bus.win_tlast_o, 0);
      chk({tag, "_tuser"}, bus.win_tuser_o, 0);
      chk({tag, "_len"}, line_len_o, '0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   initial begin
      int cyc;
      for (int k = 0; k < WIN; k++) begin
         idx[k] = 0; len_l[k] = 0; last_at[k] = -1;
         loaded[k] = 0; popped[k] = 0; hold[k] = 0; stall[k] = 0;
      end
      base = 0;
      sof  = 0;
      bus.win_tready_i = 1'b1;
      drive();

      // reset state
      repeat (3) @(posedge clk_i);
      #1;
      check_zero_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b0;
      step();
      check_zero_outputs("post_reset");

      // basic 4-pixel line
      run_line(4, 0, 1'b0, -1, 0, 1'b0, -1, 1'b0);
      // start gating on a missing unread flag
      run_line(5, 64, 1'b0, -1, 0, 1'b0, -1, 1'b1);
      // backpressure toggling every cycle
      run_line(8, 128, 1'b1, -1, 0, 1'b0, -1, 1'b0);
      // line 1 lagging for three cycles mid-line
      run_line(6, 192, 1'b0, 2, 3, 1'b0, -1, 1'b0);
      // start-of-frame marker on line 2 beat 0
      run_line(4, 256, 1'b0, -1, 0, 1'b1, -1, 1'b0);

      // reset in the middle of a line
      bus.win_tready_i = 1'b1;
      load_line(6, 320, 1'b0, -1);
      beats_out = 0;
      cyc = 0;
      while (beats_out < 2 && cyc < 100) begin
         step();
         cyc++;
      end
      if (cyc >= 100) chk("midreset_timeout", 1, 0);
      rst_i = 1'b1;
      #2;
      check_zero_outputs("midreset");
      for (int k = 0; k < WIN; k++) begin
         loaded[k] = 0; popped[k] = 0; idx[k] = 0;
      end
      sb.delete();
      hold_pend = 1'b0;
      exp_err   = 1'b0;
      prev_len  = 0;
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) begin
         step();
         chk("midreset_idle", s_busy, 0);
      end

      // line 1 signals end-of-line one beat early
      run_line(4, 384, 1'b0, -1, 0, 1'b0, 2, 1'b0);
      repeat (10) step();
      chk("err_sticky", err_o, exp_err);

      // final reset clears the sticky flag
      rst_i = 1'b1;
      #2;
      check_zero_outputs("final_reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the bench always reaches its summary.
   initial begin
      #200000;
      n_err++;
      $display("FAIL global_timeout: got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
